// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the 16-bit pipelined core.
// Takes one load/store at a time over valid/ready, waits LATENCY cycles,
// accesses an internal word array and returns a one-cycle response.
// The stall output holds the pipeline's Memory stage until that response.
module dmem_responder #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  // Index width for the array; kept at least one bit wide.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // DEPTH widened by one bit so a DEPTH of 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  // The counter starts at LATENCY-1, so WAIT spans exactly LATENCY cycles.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  // Reject any LATENCY the 4-bit wait counter cannot represent.
  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be within 1..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Out-of-range check on the full address. Low index bits alone would
  // alias addresses above DEPTH back into the array.
  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DEPTH_EXT);
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;

  logic                addr_ok_s;
  logic [IDX_W-1:0]    mem_idx_s;
  logic [DATA_W-1:0]   mem_rd_s;
  logic                mem_we_s;

  // Word storage; contents are deliberately not cleared by reset.
  logic [DATA_W-1:0]   mem [DEPTH];

  assign addr_ok_s = addr_in_range(addr_q);
  assign mem_idx_s = addr_q[IDX_W-1:0];
  assign mem_rd_s  = mem[mem_idx_s];

  // Next-state and datapath: capture in IDLE, count down in WAIT,
  // access on the final WAIT edge, then present the response for one cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          if (!addr_ok_s) begin
            // Out of range: no array write, zero data, flag the error.
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else if (wr_q) begin
            mem_we_s     = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
          end else begin
            resp_rdata_d = mem_rd_s;
            resp_err_d   = 1'b0;
          end
        end
      end

      ST_RESP: begin
        // resp_rdata keeps its value until the next response is produced.
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
      end

      default: begin
        state_d      = ST_IDLE;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
      end
    endcase
  end

  // Control and response registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Array write port. It only fires from WAIT, so a store that reset
  // interrupts before its access edge never reaches the array.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem[mem_idx_s] <= wdata_q;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

  // stall drops in RESP so the pipeline advances while it consumes resp_rdata.
  assign stall = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);

endmodule
